// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer family.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TIMER_WIDTH = 12;

   localparam logic [TIMER_WIDTH-1:0] ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

endpackage

// File: rtl/countdown_core.sv
// Countdown datapath: count register, decrementer, terminal detector, reload register.
// Build option TIMER_AUTORELOAD_EN makes the terminal step restore the reload value.
module countdown_core
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] c_o,
   output logic             is_one_o
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(ONE);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;

   assign is_one_o = (count_q == ONE_W);

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (load_i) begin
         count_d  = b_i;
         reload_d = b_i;
      end else if (step_i && (count_q != '0)) begin
`ifdef TIMER_AUTORELOAD_EN
         count_d = is_one_o ? reload_q : count_q - ONE_W;
`else
         count_d = count_q - ONE_W;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= '0;
         reload_q <= '0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign c_o = count_q;

endmodule

// File: rtl/countdown_timer_12b.sv
// Loadable down-counting timer with one-cycle terminal-count pulse.
// Build option TIMER_AUTORELOAD_EN turns expiry into a periodic reload.
module countdown_timer_12b
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic             tc,
   output logic             busy
);

   state_t state_q, state_d;
   logic   tc_q, tc_d;
   logic   busy_q, busy_d;
   logic   step;
   logic   is_one;

   // Load has priority over counting, so a same-cycle enable never decrements.
   assign step = !load && (state_q == RUN) && enable;

   countdown_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .step_i   (step),
      .b_i      (b),
      .c_o      (c),
      .is_one_o (is_one)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         tc_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (b != '0) ? RUN : IDLE;
      end else if (step && is_one) begin
`ifdef TIMER_AUTORELOAD_EN
         state_d = RUN;
`else
         state_d = DONE;
`endif
      end
   end

   always_comb begin
      tc_d   = step && is_one;
      busy_d = (state_d == RUN);
   end

   assign tc   = tc_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_countdown_timer_12b.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_countdown_timer_12b;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         load = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] b = '0;
   logic [W-1:0] c;
   logic         tc;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: remaining count, remembered length, whether armed.
   int m_count  = 0;
   int m_length = 0;
   bit m_armed  = 0;
   bit m_tick   = 0;

   always #5 clk = ~clk;

   countdown_timer_12b dut (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .enable (enable),
      .b      (b),
      .c      (c),
      .tc     (tc),
      .busy   (busy)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic step(input bit r, input bit l, input bit e, input int bv);
      @(negedge clk);
      reset  = r;
      load   = l;
      enable = e;
      b      = W'(bv);
      @(posedge clk);
      m_tick = 0;
      if (r) begin
         m_count = 0; m_length = 0; m_armed = 0;
      end else if (l) begin
         m_count = bv; m_length = bv; m_armed = (bv != 0);
      end else if (m_armed && e) begin
         if (m_count == 1) begin
            m_tick = 1;
`ifdef TIMER_AUTORELOAD_EN
            m_count = m_length;
`else
            m_count = 0;
            m_armed = 0;
`endif
         end else begin
            m_count = m_count - 1;
         end
      end
      #1;
      chk("c", int'(c), m_count);
      chk("tc", int'(tc), int'(m_tick));
      chk("busy", int'(busy), int'(m_armed));
      $display("txn r=%0d l=%0d e=%0d b=%0d -> c=%0d tc=%0d busy=%0d", r, l, e, bv, c, tc, busy);
   endtask

   initial begin
      // Reset beats load.
      step(1, 1, 0, 9);
      step(1, 1, 0, 9);
      chk("reset_c", int'(c), 0);

`ifndef TIMER_AUTORELOAD_EN
      // Full countdown of 5, then c holds at 0.
      step(0, 1, 0, 5);
      for (int i = 4; i >= 0; i--) begin
         step(0, 0, 1, 0);
         chk("cd5_c", int'(c), i);
         chk("cd5_tc", int'(tc), (i == 0) ? 1 : 0);
      end
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("hold0", int'(c), 0);

      // Gapped enable.
      step(0, 1, 0, 3);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      chk("gap_hold", int'(c), 2);
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("gap_tc", int'(tc), 1);
`endif

      // Load wins over enable mid-run.
      step(0, 1, 0, 7);
      step(0, 1, 1, 12'hFFF);
      chk("reload_c", int'(c), 4095);
      chk("reload_busy", int'(busy), 1);
      step(0, 0, 1, 0);

      // Reset mid-run, then enable has no effect.
      step(0, 1, 0, 100);
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      step(0, 0, 1, 0);
      chk("rst_mid_c", int'(c), 0);

      // Load of zero disarms.
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);

`ifdef TIMER_AUTORELOAD_EN
      step(0, 1, 0, 2);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, 0);
         chk("ar_c", int'(c), (i % 2 == 0) ? 1 : 2);
         chk("ar_busy", int'(busy), 1);
      end
`endif

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         bit r, l, e;
         int bv;
         r  = ($urandom_range(0, 99) < 2);
         l  = ($urandom_range(0, 99) < 8);
         e  = ($urandom_range(0, 99) < 75);
         bv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 12);
         step(r, l, e, bv);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
